// File: rtl/board_write_ctl.sv
// ----------------------------------------------------------------------------
// board_write_ctl
// Write-side controller for one board_mem instance (X_SIZE x Y_SIZE grid of
// 2-bit cells). Arbitrates the single write port between two requesters
// (A: ship placement / mouse, B: shot result / game logic) with round-robin
// tie-breaking, and runs a full-board clear sweep on request or after reset.
//
// Ports
//   clk, rst                 control clock, synchronous active-high reset
//   clear_req                single-cycle request to clear the whole board
//   clear_busy               high for every cycle of a clear sweep write
//   a_valid/a_x/a_y/a_data   requester A write request
//   a_ready                  A accepted this cycle (combinational)
//   b_valid/b_x/b_y/b_data   requester B write request
//   b_ready                  B accepted this cycle (combinational)
//   write_addr               board_mem address {y[3:0], x[3:0]} (registered)
//   write_data               board_mem cell value (registered)
//   write_enable             board_mem write strobe (registered)
//   drop                     one-cycle pulse: accepted request was off-board
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arbitrate A/B, one accepted request per cycle
// CLEAR  | sweeping CLEAR_VALUE over every valid cell, requesters stalled
// ----------------------------------------------------------------------------
module board_write_ctl #(
    parameter int         X_SIZE         = 12,
    parameter int         Y_SIZE         = 12,
    parameter logic [1:0] CLEAR_VALUE    = 2'b00,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_req,
    output logic       clear_busy,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [3:0] a_x,
    input  logic [3:0] a_y,
    input  logic [1:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [3:0] b_x,
    input  logic [3:0] b_y,
    input  logic [1:0] b_data,
    output logic [7:0] write_addr,
    output logic [1:0] write_data,
    output logic       write_enable,
    output logic       drop
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [3:0] X_LAST = 4'(X_SIZE - 1);
    localparam logic [3:0] Y_LAST = 4'(Y_SIZE - 1);
    localparam logic [4:0] X_LIM  = 5'(X_SIZE);
    localparam logic [4:0] Y_LIM  = 5'(Y_SIZE);

    state_t     state_q, state_d;
    logic [3:0] x_cnt_q, x_cnt_d;
    logic [3:0] y_cnt_q, y_cnt_d;
    // 1: B won the most recent tie, so A wins the next one.
    logic       rr_last_b_q, rr_last_b_d;
    // Pending sweep requested by reset itself; consumed on the first live edge.
    logic       boot_clear_q, boot_clear_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [1:0] data_q, data_d;
    logic       drop_q, drop_d;
    logic       busy_q, busy_d;

    logic       start_clear;
    logic       idle_arb;
    logic       a_grant, b_grant;
    logic [3:0] sel_x, sel_y;
    logic [1:0] sel_data;
    logic       sel_in_range;

    assign start_clear = clear_req | boot_clear_q;
    assign idle_arb    = (state_q == IDLE) && !rst && !start_clear;
    assign a_grant     = idle_arb && a_valid && (!b_valid || rr_last_b_q);
    assign b_grant     = idle_arb && b_valid && (!a_valid || !rr_last_b_q);

    assign a_ready      = a_grant;
    assign b_ready      = b_grant;
    assign write_enable = we_q;
    assign write_addr   = addr_q;
    assign write_data   = data_q;
    assign drop         = drop_q;
    assign clear_busy   = busy_q;

    always_comb begin
        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        rr_last_b_d  = rr_last_b_q;
        boot_clear_d = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        drop_d       = 1'b0;
        busy_d       = 1'b0;

        sel_x        = a_grant ? a_x    : b_x;
        sel_y        = a_grant ? a_y    : b_y;
        sel_data     = a_grant ? a_data : b_data;
        sel_in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);

        case (state_q)
            IDLE: begin
                if (start_clear) begin
                    // First sweep write goes out on the entry edge so the
                    // sweep occupies exactly X_SIZE*Y_SIZE cycles.
                    state_d = CLEAR;
                    x_cnt_d = 4'd0;
                    y_cnt_d = 4'd0;
                    we_d    = 1'b1;
                    addr_d  = 8'h00;
                    data_d  = CLEAR_VALUE;
                    busy_d  = 1'b1;
                end else if (a_grant || b_grant) begin
                    // The round-robin pointer only moves on a genuine tie.
                    if (a_valid && b_valid) begin
                        rr_last_b_d = b_grant;
                    end
                    if (sel_in_range) begin
                        we_d   = 1'b1;
                        addr_d = {sel_y, sel_x};
                        data_d = sel_data;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if ((x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST)) begin
                    state_d = IDLE;
                end else begin
                    if (x_cnt_q == X_LAST) begin
                        x_cnt_d = 4'd0;
                        y_cnt_d = y_cnt_q + 4'd1;
                    end else begin
                        x_cnt_d = x_cnt_q + 4'd1;
                    end
                    we_d   = 1'b1;
                    addr_d = {y_cnt_d, x_cnt_d};
                    data_d = CLEAR_VALUE;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_cnt_q      <= 4'd0;
            y_cnt_q      <= 4'd0;
            rr_last_b_q  <= 1'b1;
            boot_clear_q <= CLEAR_ON_RESET;
            we_q         <= 1'b0;
            addr_q       <= 8'h00;
            data_q       <= 2'b00;
            drop_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            rr_last_b_q  <= rr_last_b_d;
            boot_clear_q <= boot_clear_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
        end
    end

endmodule
